mul_share_ctrl: RTL

- Round-robin controller that shares one serial radix-4 Booth multiplier (`signed_multiplier`: 34x34 signed, 68-bit product) between NREQ requesters.
- Accepts one operand pair at a time, pulses the multiplier start, and counts the multiplier's fixed latency.
- Captures the product before the multiplier's free-running counter can overwrite it, then returns it with the requester id under a valid/ready handshake.
- Sits between the requester clients and the single multiplier instance.

---
 rtl/mul_share_pkg.sv | 21 ++
 rtl/mul_share_if.sv | 29 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/mul_share_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
package mul_share_pkg;

    localparam int OPW     = 34;
    localparam int PRODW   = 2 * OPW;
    localparam int MUL_LAT = 19;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CAPT,
        RESP
    } state_t;

    // A lone requester still needs a 1-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_share_if.sv
// Requester/consumer side of the shared multiplier: operand offers in, tagged products out.
interface mul_share_if #(
    parameter int NREQ = 4,
    parameter int OPW  = mul_share_pkg::OPW
);
    import mul_share_pkg::*;

    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [2*OPW-1:0]    rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [IDW-1:0] pos;

    // The last winner is visited last (k == NREQ), giving it lowest priority.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = IDW'((int'(last_grant) + k) % NREQ);
            if (enable && !grant_any && req[pos]) begin
                grant[pos] = 1'b1;
                grant_idx  = pos;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin front end for one serial signed multiplier: accept, start, wait fixed latency,
// capture before the multiplier's free-running counter overwrites it, then hand back with id.
module mul_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int OPW     = mul_share_pkg::OPW,
    parameter int MUL_LAT = mul_share_pkg::MUL_LAT
) (
    input  logic              clk,
    input  logic              rst,
    mul_share_if.slave        bus,
    output logic              busy,
    output logic              mul_start,
    output logic [OPW-1:0]    mul_a,
    output logic [OPW-1:0]    mul_b,
    input  logic [2*OPW-1:0]  mul_s
);
    import mul_share_pkg::*;

    localparam int IDW  = id_width(NREQ);
    localparam int CNTW = $clog2(MUL_LAT);

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   rsp_id_q;
    logic [2*OPW-1:0] rsp_prod_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .enable     (state_q == IDLE),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // Reset leaves last_grant at the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            cnt        <= '0;
            last_grant <= IDW'(NREQ - 1);
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_id_q   <= '0;
            rsp_prod_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (grant_any) begin
                    mul_a      <= bus.req_a[grant_idx*OPW +: OPW];
                    mul_b      <= bus.req_b[grant_idx*OPW +: OPW];
                    rsp_id_q   <= grant_idx;
                    last_grant <= grant_idx;
                end
                START:   cnt        <= '0;
                WAIT:    cnt        <= cnt + 1'b1;
                CAPT:    rsp_prod_q <= mul_s;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        mul_start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy          = 1'b0;
                bus.req_ready = grant;
                if (grant_any) state_d = START;
            end
            START: begin
                mul_start = 1'b1;
                state_d   = WAIT;
            end
            // Leaving at MUL_LAT-2 puts CAPT exactly on the first valid-product cycle.
            WAIT:    if (cnt == CNTW'(MUL_LAT - 2)) state_d = CAPT;
            CAPT:    state_d = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rsp_id   = rsp_id_q;
    assign bus.rsp_prod = rsp_prod_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
    a_start_pulse:  assert property (@(posedge clk) disable iff (rst) mul_start |=> !mul_start);

endmodule
